regfile_init_sequencer: RTL and testbench

- Controller that sequences register-file initialisation using the shared constant value generator (W-bit, clear input, combinational output).
- On start (or automatically after reset), writes 0 to registers 0..N_REGS-1, then writes the generator's constant to SPECIAL_ADDR (e.g. the stack pointer).
- Muxes the CPU write port onto the register file when idle and stalls the CPU while busy.
- Sits between the datapath write-back path, the constant generator and the register file.

---
 rtl/regfile_init_sequencer_pkg.sv | 12 +
 rtl/regfile_init_sequencer.sv | 95 +++++++++
 tb/tb_regfile_init_sequencer.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_init_sequencer_pkg.sv
// Shared definitions for the register-file initialisation sequencer.
// The state encodings are fixed so that other blocks and debug tools can decode them.
package regfile_init_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_LOAD  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/regfile_init_sequencer.sv
// Sequences register-file initialisation: clears registers 0..N_REGS-1, then loads the
// generator constant into SPECIAL_ADDR. The CPU write port passes through while idle.
module regfile_init_sequencer
  import regfile_init_sequencer_pkg::*;
#(
  parameter int W            = 32,
  parameter int ADDR_W       = 4,
  parameter int N_REGS       = 16,
  parameter int SPECIAL_ADDR = 15,
  parameter bit AUTO_START   = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [W-1:0]      cpu_wdata,
  input  logic [W-1:0]      const_in,
  output logic              const_clear,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_addr,
  output logic [W-1:0]      rf_wdata,
  output logic              busy,
  output logic              done,
  output logic              cpu_stall
);

  // The last index is compared rather than counting past it, so N_REGS = 2^ADDR_W
  // never needs a wider counter.
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_REGS - 1);
  localparam logic [ADDR_W-1:0] SPEC_ADDR = ADDR_W'(SPECIAL_ADDR);

  state_e            state;
  logic [ADDR_W-1:0] cnt;
  logic              auto_pend;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      auto_pend <= AUTO_START;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start || auto_pend) begin
            state     <= ST_CLEAR;
            cnt       <= '0;
            auto_pend <= 1'b0;
          end
        end
        ST_CLEAR: begin
          if (cnt == LAST_ADDR) state <= ST_LOAD;
          else                  cnt   <= cnt + ADDR_W'(1);
        end
        ST_LOAD: state <= ST_DONE;
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // NOTE: every output gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    rf_we       = cpu_we;
    rf_addr     = cpu_addr;
    rf_wdata    = cpu_wdata;
    const_clear = 1'b1;
    busy        = 1'b0;
    done        = 1'b0;
    case (state)
      ST_CLEAR: begin
        busy     = 1'b1;
        rf_we    = 1'b1;
        rf_addr  = cnt;
        rf_wdata = const_in;
      end
      ST_LOAD: begin
        busy        = 1'b1;
        const_clear = 1'b0;
        rf_we       = 1'b1;
        rf_addr     = SPEC_ADDR;
        rf_wdata    = const_in;
      end
      ST_DONE: done = 1'b1;
      default: ;
    endcase
  end

  // CPU writes arriving while busy are dropped, so the CPU must hold off.
  assign cpu_stall = busy;

endmodule

// File: tb/tb_regfile_init_sequencer.sv
// Self-checking bench: instance A (16 regs, auto start) against a schedule-index model,
// instance B (4 regs, special addr 2, manual start) against a vector table.
module tb_regfile_init_sequencer;

  localparam logic [31:0] GEN_VAL = 32'd5;
  localparam int NA = 16, SA_A = 15;

  typedef struct packed {
    logic        start;
    logic        cpu_we;
    logic [3:0]  cpu_addr;
    logic [31:0] cpu_wdata;
  } in_t;

  typedef struct packed {
    logic        const_clear;
    logic        rf_we;
    logic [3:0]  rf_addr;
    logic [31:0] rf_wdata;
    logic        busy;
    logic        done;
    logic        cpu_stall;
  } out_t;

  typedef struct {
    in_t  i;
    out_t o;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_a = 1'b0, reset_b = 1'b0;
  in_t  in_a, in_b;

  logic        a_cc, a_we, a_busy, a_done, a_stall;
  logic [3:0]  a_addr;
  logic [31:0] a_wd, const_a;
  logic        b_cc, b_we, b_busy, b_done, b_stall;
  logic [3:0]  b_addr;
  logic [31:0] b_wd, const_b;
  out_t        out_a, out_b;

  // Behavioural constant generator: clear selects 0, otherwise its value.
  assign const_a = a_cc ? 32'd0 : GEN_VAL;
  assign const_b = b_cc ? 32'd0 : GEN_VAL;
  assign out_a = {a_cc, a_we, a_addr, a_wd, a_busy, a_done, a_stall};
  assign out_b = {b_cc, b_we, b_addr, b_wd, b_busy, b_done, b_stall};

  regfile_init_sequencer #(
    .W(32), .ADDR_W(4), .N_REGS(NA), .SPECIAL_ADDR(SA_A), .AUTO_START(1'b1)
  ) dut_a (
    .clk(clk), .reset(reset_a), .start(in_a.start), .cpu_we(in_a.cpu_we),
    .cpu_addr(in_a.cpu_addr), .cpu_wdata(in_a.cpu_wdata), .const_in(const_a),
    .const_clear(a_cc), .rf_we(a_we), .rf_addr(a_addr), .rf_wdata(a_wd),
    .busy(a_busy), .done(a_done), .cpu_stall(a_stall)
  );

  regfile_init_sequencer #(
    .W(32), .ADDR_W(4), .N_REGS(4), .SPECIAL_ADDR(2), .AUTO_START(1'b0)
  ) dut_b (
    .clk(clk), .reset(reset_b), .start(in_b.start), .cpu_we(in_b.cpu_we),
    .cpu_addr(in_b.cpu_addr), .cpu_wdata(in_b.cpu_wdata), .const_in(const_b),
    .const_clear(b_cc), .rf_we(b_we), .rf_addr(b_addr), .rf_wdata(b_wd),
    .busy(b_busy), .done(b_done), .cpu_stall(b_stall)
  );

  // Register files written by whatever the sequencer drives.
  logic [31:0] mem_a [16];
  logic [31:0] mem_b [16];
  always @(posedge clk) if (a_we) mem_a[a_addr] <= a_wd;
  always @(posedge clk) if (b_we) mem_b[b_addr] <= b_wd;

  // Reference: position in the write schedule (-1 idle, 0..N-1 clears, N load, N+1 done).
  int   pos_a;
  logic auto_a;
  always @(posedge clk or posedge reset_a) begin
    if (reset_a) begin
      pos_a  <= -1;
      auto_a <= 1'b1;
    end else if (pos_a < 0) begin
      if (in_a.start || auto_a) begin
        pos_a  <= 0;
        auto_a <= 1'b0;
      end
    end else if (pos_a < NA + 1) pos_a <= pos_a + 1;
    else pos_a <= -1;
  end

  function automatic out_t model_out(int pos, in_t i, int n, int sa);
    out_t o;
    o.rf_we       = i.cpu_we;
    o.rf_addr     = i.cpu_addr;
    o.rf_wdata    = i.cpu_wdata;
    o.const_clear = 1'b1;
    o.busy        = 1'b0;
    o.done        = (pos == n + 1);
    if (pos >= 0 && pos < n) begin
      o.rf_we    = 1'b1;
      o.rf_addr  = 4'(pos);
      o.rf_wdata = 32'd0;
      o.busy     = 1'b1;
    end else if (pos == n) begin
      o.rf_we       = 1'b1;
      o.rf_addr     = 4'(sa);
      o.rf_wdata    = GEN_VAL;
      o.const_clear = 1'b0;
      o.busy        = 1'b1;
    end
    o.cpu_stall = o.busy;
    return o;
  endfunction

  function automatic in_t mk_in(logic s, logic we, logic [3:0] a, logic [31:0] d);
    mk_in = '{start: s, cpu_we: we, cpu_addr: a, cpu_wdata: d};
  endfunction

  function automatic out_t mk_out(logic cc, logic we, logic [3:0] a, logic [31:0] d,
                                  logic bsy, logic dn);
    mk_out = '{const_clear: cc, rf_we: we, rf_addr: a, rf_wdata: d,
               busy: bsy, done: dn, cpu_stall: bsy};
  endfunction

  int checks = 0, failures = 0;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  int n_we, n_done, n_busy;
  bit bad_cpu;

  task automatic clr_counts();
    n_we = 0; n_done = 0; n_busy = 0; bad_cpu = 0;
  endtask

  // Entered just after a rising edge; drives, checks at the falling edge, returns after the next rise.
  task automatic run_a(in_t i, int ncyc, string name);
    for (int c = 0; c < ncyc; c++) begin
      in_a = i;
      @(negedge clk);
      check(name, 64'(out_a), 64'(model_out(pos_a, in_a, NA, SA_A)));
      if (a_we)   n_we++;
      if (a_done) n_done++;
      if (a_busy) n_busy++;
      if (a_we && a_addr == 4'd7 && a_wd == 32'h1234) bad_cpu = 1'b1;
      @(posedge clk);
      #1;
    end
  endtask

  vec_t tbl [11];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    in_t r;
    in_a = '0;
    in_b = '0;
    reset_a = 1'b1;
    reset_b = 1'b1;
    clr_counts();

    // During reset: start ignored, CPU passes through; preload mem_a with all-ones.
    @(posedge clk);
    #1;
    for (int k = 0; k < 16; k++) run_a(mk_in(1'b1, 1'b1, 4'(k), 32'hFFFF_FFFF), 1, "reset_pass");
    in_a = '0;
    @(negedge clk);
    reset_a = 1'b0;
    reset_b = 1'b0;
    @(posedge clk);
    #1;

    // Automatic sequence after reset.
    clr_counts();
    run_a('0, NA + 2, "auto_seq");
    check("auto_writes", 64'(n_we), 64'(NA + 1));
    check("auto_busy_cycles", 64'(n_busy), 64'(NA + 1));
    check("auto_done_pulses", 64'(n_done), 64'd1);
    for (int k = 0; k < 16; k++)
      check($sformatf("auto_mem[%0d]", k), 64'(mem_a[k]), 64'((k == SA_A) ? GEN_VAL : 32'd0));

    // Idle CPU passthrough, no sequence.
    clr_counts();
    run_a(mk_in(1'b0, 1'b1, 4'd3, 32'hDEAD_BEEF), 3, "idle_cpu");
    check("idle_cpu_mem3", 64'(mem_a[3]), 64'h0000_0000_DEAD_BEEF);
    check("idle_no_busy", 64'(n_busy), 64'd0);

    // Start pulse; CPU write and repeated start during CLEAR are dropped.
    clr_counts();
    run_a(mk_in(1'b1, 1'b0, 4'd0, 32'd0), 1, "start_pulse");
    run_a(mk_in(1'b1, 1'b1, 4'd7, 32'h1234), 5, "clear_cpu");
    run_a('0, NA + 2 - 5, "clear_rest");
    run_a('0, 2, "no_restart");
    check("manual_writes", 64'(n_we), 64'(NA + 1));
    check("manual_done_pulses", 64'(n_done), 64'd1);
    check("manual_busy_cycles", 64'(n_busy), 64'(NA + 1));
    check("cpu_write_dropped", 64'(bad_cpu), 64'd0);

    // Asynchronous reset mid-sequence at cnt=6, then auto restart from address 0.
    run_a(mk_in(1'b1, 1'b0, 4'd0, 32'd0), 1, "start_for_reset");
    run_a('0, 6, "pre_reset");
    in_a = mk_in(1'b0, 1'b1, 4'd9, 32'hA5A5_A5A5);
    #2;
    reset_a = 1'b1;
    #1;
    check("async_reset_out", 64'(out_a), 64'(mk_out(1'b1, 1'b1, 4'd9, 32'hA5A5_A5A5, 1'b0, 1'b0)));
    check("async_reset_model", 64'(out_a), 64'(model_out(pos_a, in_a, NA, SA_A)));
    in_a = '0;
    @(negedge clk);
    reset_a = 1'b0;
    @(posedge clk);
    #1;
    clr_counts();
    run_a('0, NA + 2, "restart_seq");
    check("restart_writes", 64'(n_we), 64'(NA + 1));
    check("restart_done_pulses", 64'(n_done), 64'd1);

    // Start held high: back-to-back sequences with one idle cycle between.
    clr_counts();
    run_a(mk_in(1'b1, 1'b0, 4'd0, 32'd0), 2 * (NA + 3), "hold_start");
    check("hold_done_pulses", 64'(n_done), 64'd2);
    check("hold_busy_cycles", 64'(n_busy), 64'(2 * (NA + 1)));

    // Randomised traffic against the model.
    for (int k = 0; k < 400; k++) begin
      r.start     = ($urandom_range(0, 15) == 0);
      r.cpu_we    = 1'($urandom);
      r.cpu_addr  = 4'($urandom);
      r.cpu_wdata = $urandom;
      run_a(r, 1, "random");
    end

    // Instance B (N_REGS=4, SPECIAL_ADDR=2, manual start) vector table.
    tbl[0]  = '{mk_in(0, 1, 4'd3, 32'hDEAD_BEEF), mk_out(1, 1, 4'd3, 32'hDEAD_BEEF, 0, 0)};
    tbl[1]  = '{mk_in(0, 0, 4'd4, 32'd0),         mk_out(1, 0, 4'd4, 32'd0, 0, 0)};
    tbl[2]  = '{mk_in(1, 1, 4'd9, 32'h55),        mk_out(1, 1, 4'd9, 32'h55, 0, 0)};
    tbl[3]  = '{mk_in(1, 1, 4'd7, 32'h1234),      mk_out(1, 1, 4'd0, 32'd0, 1, 0)};
    tbl[4]  = '{mk_in(0, 0, 4'd0, 32'd0),         mk_out(1, 1, 4'd1, 32'd0, 1, 0)};
    tbl[5]  = '{mk_in(1, 0, 4'd0, 32'd0),         mk_out(1, 1, 4'd2, 32'd0, 1, 0)};
    tbl[6]  = '{mk_in(0, 1, 4'd7, 32'h1234),      mk_out(1, 1, 4'd3, 32'd0, 1, 0)};
    tbl[7]  = '{mk_in(0, 0, 4'd0, 32'd0),         mk_out(0, 1, 4'd2, GEN_VAL, 1, 0)};
    tbl[8]  = '{mk_in(1, 1, 4'd6, 32'h77),        mk_out(1, 1, 4'd6, 32'h77, 0, 1)};
    tbl[9]  = '{mk_in(0, 0, 4'd0, 32'd0),         mk_out(1, 0, 4'd0, 32'd0, 0, 0)};
    tbl[10] = '{mk_in(0, 0, 4'd0, 32'd0),         mk_out(1, 0, 4'd0, 32'd0, 0, 0)};
    for (int k = 0; k < 11; k++) begin
      in_b = tbl[k].i;
      @(negedge clk);
      check($sformatf("tbl_b[%0d]", k), 64'(out_b), 64'(tbl[k].o));
      @(posedge clk);
      #1;
    end
    check("b_mem0", 64'(mem_b[0]), 64'd0);
    check("b_mem2_special", 64'(mem_b[2]), 64'(GEN_VAL));
    check("b_mem3_cleared", 64'(mem_b[3]), 64'd0);
    check("b_mem9_cpu", 64'(mem_b[9]), 64'h55);
    check("b_mem6_done_cpu", 64'(mem_b[6]), 64'h77);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
